// File: rtl/spi_exp_pkg.sv
// Shared definitions for the SPI IO expander: sequencer state encoding,
// command-byte bit positions and the wrapped address increment.
package spi_exp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } seq_state_e;

  // Bit positions for the default 8-bit byte; wider bytes shift both up.
  localparam int SPI_DATA_W  = 8;
  localparam int CMD_RW_BIT  = SPI_DATA_W - 1;
  localparam int CMD_INC_BIT = SPI_DATA_W - 2;

  // Next burst address: NUM_REGS-1 wraps to 0, anything else counts up
  // modulo 2^addr_w (so out-of-range addresses keep rolling until they wrap).
  function automatic logic [31:0] wrap_next(input logic [31:0] addr,
                                            input logic [31:0] num_regs,
                                            input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    if (addr == num_regs - 32'd1) begin
      return 32'd0;
    end
    return (addr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/spi_addr_counter.sv
// Register address counter: loads the decoded command address and advances
// with wrap at NUM_REGS-1; reports range for the current and next address.
module spi_addr_counter
  import spi_exp_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range,
  output logic              next_in_range
);

  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_value;
    end else if (inc) begin
      addr_d = ADDR_W'(wrap_next(32'(addr_q), NUM_REGS_U, ADDR_W));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr          = addr_q;
  assign in_range      = (32'(addr_q) < NUM_REGS_U);
  // Range of the address that will be on reg_addr when a strobe decided now fires.
  assign next_in_range = (32'(addr_d) < NUM_REGS_U);

endmodule

// File: rtl/spi_cmd_addr_sequencer.sv
// Decodes the command byte of each SPI frame and issues one registered
// register read/write strobe per data byte, with optional burst increment.
module spi_cmd_addr_sequencer
  import spi_exp_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_in,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd,
  output logic              reg_wr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              rw,
  output logic              addr_err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int RW_BIT  = CMD_RW_BIT + (DATA_W - SPI_DATA_W);
  localparam int INC_BIT = CMD_INC_BIT + (DATA_W - SPI_DATA_W);

  seq_state_e        state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              inc_q, inc_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              cnt_load;
  logic              cnt_inc;
  logic              cnt_in_range;
  logic              cnt_next_in_range;
  logic              strobe_ok;

  // Reads advance on the byte (prefetch next); writes advance after their strobe.
  assign cnt_load = !cs_n && byte_valid && (state_q == S_CMD);
  assign cnt_inc  = !cs_n && (state_q == S_DATA) && inc_q &&
                    (rw_q ? byte_valid : wr_q);
  assign strobe_ok = (cnt_load || cnt_inc) ? cnt_next_in_range : cnt_in_range;

  spi_addr_counter #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_addr_counter (
    .clk          (clk),
    .rst          (rst),
    .load         (cnt_load),
    .load_value   (byte_in[ADDR_W-1:0]),
    .inc          (cnt_inc),
    .addr         (reg_addr),
    .in_range     (cnt_in_range),
    .next_in_range(cnt_next_in_range)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    inc_d   = inc_q;
    err_d   = err_q;
    if (cs_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          err_d   = 1'b0;
        end
        S_CMD: begin
          if (byte_valid) begin
            state_d = S_DATA;
            rw_d    = byte_in[RW_BIT];
            inc_d   = byte_in[INC_BIT] && (AUTO_INC != 0);
            if (byte_in[RW_BIT]) begin
              if (strobe_ok) rd_d = 1'b1;
              else           err_d = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (byte_valid) begin
            if (rw_q) begin
              if (strobe_ok) rd_d = 1'b1;
              else           err_d = 1'b1;
            end else begin
              wdata_d = byte_in;
              if (strobe_ok) wr_d = 1'b1;
              else           err_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      inc_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      inc_q   <= inc_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign reg_rd    = rd_q;
  assign reg_wr    = wr_q;
  assign reg_wdata = wdata_q;
  assign rw        = rw_q;
  assign addr_err  = err_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule
